// File: rtl/i2s_slave_tx.sv
// I2S slave transmitter: oversamples an external BCLK/LRCLK pair on clk_in and
// shifts a stereo sample pair out MSB first, fed through a one-deep holding buffer.
module i2s_slave_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              bclk_in,
  input  logic              lrclk_in,
  input  logic [DATA_W-1:0] sample_l,
  input  logic [DATA_W-1:0] sample_r,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sdata_out,
  output logic              underrun
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic              bclk_s1, bclk_s2, bclk_h;
  logic              lr_s1, lr_s2, lr_h;
  logic              rise_evt, fall_evt;
  logic              lr_prev, primed, load_pend, channel;
  logic              buf_full;
  logic [DATA_W-1:0] buf_l, buf_r;
  logic [DATA_W-1:0] fl, fr, shreg, word_sel;
  logic [CNT_W-1:0]  bit_cnt;
  logic              boundary, left_bnd, accept;

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge value; blocking '=' here would collapse the synchroniser chain.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1  <= 1'b0;
      bclk_s2  <= 1'b0;
      bclk_h   <= 1'b0;
      lr_s1    <= 1'b0;
      lr_s2    <= 1'b0;
      lr_h     <= 1'b0;
      rise_evt <= 1'b0;
      fall_evt <= 1'b0;
    end else begin
      bclk_s1  <= bclk_in;
      bclk_s2  <= bclk_s1;
      bclk_h   <= bclk_s2;
      lr_s1    <= lrclk_in;
      lr_s2    <= lr_s1;
      lr_h     <= lr_s2;
      // Registered edge flags line up with lr_h, which holds LRCLK as seen at the same BCLK edge.
      rise_evt <= bclk_s2 & ~bclk_h;
      fall_evt <= ~bclk_s2 & bclk_h;
    end
  end

  assign boundary     = rise_evt & primed & (lr_h != lr_prev);
  assign left_bnd     = boundary & ~lr_h;
  assign accept       = sample_valid & ~buf_full;
  assign sample_ready = ~buf_full;
  assign word_sel     = channel ? fr : fl;

  // NOTE: the holding-buffer data needs no reset; buf_full qualifies it, and
  // leaving wide datapath registers out of the reset tree keeps it small.
  always_ff @(posedge clk_in) begin
    if (accept && !left_bnd) begin
      buf_l <= sample_l;
      buf_r <= sample_r;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      lr_prev   <= 1'b0;
      primed    <= 1'b0;
      load_pend <= 1'b0;
      channel   <= 1'b0;
      buf_full  <= 1'b0;
      fl        <= '0;
      fr        <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      sdata_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (rise_evt) begin
        primed  <= 1'b1;
        lr_prev <= lr_h;
      end

      if (boundary) begin
        channel   <= lr_h;
        load_pend <= 1'b1;
      end

      // A left boundary consumes the buffered pair, or the producer's pair if it
      // arrives on this very edge, otherwise the frame goes out as silence.
      if (left_bnd) begin
        if (buf_full) begin
          fl       <= buf_l;
          fr       <= buf_r;
          buf_full <= 1'b0;
        end else if (sample_valid) begin
          fl <= sample_l;
          fr <= sample_r;
        end else begin
          fl       <= '0;
          fr       <= '0;
          underrun <= 1'b1;
        end
      end else if (accept) begin
        buf_full <= 1'b1;
      end

      if (fall_evt) begin
        if (load_pend) begin
          sdata_out <= word_sel[DATA_W-1];
          shreg     <= {word_sel[DATA_W-2:0], 1'b0};
          bit_cnt   <= CNT_ONE;
          load_pend <= 1'b0;
        end else if (bit_cnt < CNT_FULL) begin
          sdata_out <= shreg[DATA_W-1];
          shreg     <= {shreg[DATA_W-2:0], 1'b0};
          bit_cnt   <= bit_cnt + CNT_ONE;
        end else begin
          sdata_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_tx.sv
// Bench for i2s_slave_tx: drives BCLK/LRCLK as an I2S master, samples sdata at
// every BCLK rise like a receiver, and tracks expected words with a frame-level model.
module tb_i2s_slave_tx;

  localparam int DATA_W = 16;
  localparam int HALF   = 8;  // clk_in cycles per BCLK half period
  localparam int LAT    = 4;  // clk_in edges from a BCLK pin edge to the block's reaction

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              bclk_in;
  logic              lrclk_in;
  logic [DATA_W-1:0] sample_l;
  logic [DATA_W-1:0] sample_r;
  logic              sample_valid;
  logic              sample_ready;
  logic              sdata_out;
  logic              underrun;

  i2s_slave_tx #(.DATA_W(DATA_W)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .bclk_in     (bclk_in),
    .lrclk_in    (lrclk_in),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sdata_out   (sdata_out),
    .underrun    (underrun)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Frame-level model: one holding slot, the pair owned by the current frame,
  // and the word the current channel is transmitting.
  int                cyc      = 0;
  int                act_at   = -1;
  logic              act_left = 1'b0;
  logic              m_full;
  logic              m_und;
  logic [DATA_W-1:0] m_bl, m_br, m_fr, cur_word;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_full   <= 1'b0;
      m_und    <= 1'b0;
      m_fr     <= '0;
      cur_word <= '0;
    end else begin
      m_und <= 1'b0;
      if (cyc == act_at && act_left) begin
        if (m_full) begin
          m_fr     <= m_br;
          cur_word <= m_bl;
          m_full   <= 1'b0;
        end else if (sample_valid) begin
          m_fr     <= sample_r;
          cur_word <= sample_l;
        end else begin
          m_fr     <= '0;
          cur_word <= '0;
          m_und    <= 1'b1;
        end
      end else begin
        if (sample_valid && !m_full) begin
          m_bl   <= sample_l;
          m_br   <= sample_r;
          m_full <= 1'b1;
        end
        if (cyc == act_at) cur_word <= m_fr;
      end
    end
  end

  int und_cnt   = 0;
  int ready_low = 0;
  bit cmp_on    = 1'b0;

  always @(posedge clk_in) begin
    #3;
    if (cmp_on) begin
      check("ready", 32'(sample_ready), 32'(!m_full));
      check("underrun", 32'(underrun), 32'(m_und));
      if (!rst_n) check("rst_sdata", 32'(sdata_out), 32'd0);
    end
    if (underrun === 1'b1) und_cnt++;
    if (sample_ready === 1'b0) ready_low++;
  end

  // Receiver-side view of the serial stream
  bit                d_primed  = 1'b0;
  logic              d_lrprev  = 1'b0;
  int                k         = DATA_W;
  logic [DATA_W-1:0] rx_word   = '0;
  logic [DATA_W-1:0] rx_last_l = '0;
  logic [DATA_W-1:0] rx_last_r = '0;
  logic              rx_ch     = 1'b0;
  bit                stop_prod = 1'b0;

  task automatic drv_reset();
    d_primed = 1'b0;
    d_lrprev = 1'b0;
    k        = DATA_W;
    act_at   = -1;
  endtask

  // mode 0: plain cycle; 1: present a pair exactly on the left-boundary edge;
  // 2: pulse reset during the low half.
  task automatic bclk_cycle(input logic lr, input int mode,
                            input logic [DATA_W-1:0] il, input logic [DATA_W-1:0] ir);
    int hi_wait;
    @(negedge clk_in);
    bclk_in  = 1'b0;
    lrclk_in = lr;
    if (mode == 2) begin
      repeat (5) @(negedge clk_in);
      rst_n = 1'b0;
      #1;
      check("rst_async_sdata", 32'(sdata_out), 32'd0);
      check("rst_async_ready", 32'(sample_ready), 32'd1);
      drv_reset();
      @(negedge clk_in);
      rst_n = 1'b1;
      repeat (HALF - 7) @(negedge clk_in);
    end else begin
      repeat (HALF - 1) @(negedge clk_in);
    end

    if (k < DATA_W) begin
      check("sdata_bit", 32'(sdata_out), 32'(cur_word[DATA_W-1-k]));
      rx_word = {rx_word[DATA_W-2:0], sdata_out};
      if (k == DATA_W - 1) begin
        if (rx_ch) rx_last_r = rx_word;
        else       rx_last_l = rx_word;
      end
    end else begin
      check("sdata_pad", 32'(sdata_out), 32'd0);
    end
    if (k < 1000) k++;

    @(negedge clk_in);
    bclk_in = 1'b1;
    hi_wait = HALF - 1;
    if (!d_primed) begin
      d_primed = 1'b1;
      d_lrprev = lr;
    end else if (lr !== d_lrprev) begin
      d_lrprev = lr;
      act_at   = cyc + LAT - 1;
      act_left = (lr == 1'b0);
      k        = 0;
      rx_ch    = lr;
      if (mode == 1 && lr == 1'b0) begin
        repeat (LAT - 1) @(negedge clk_in);
        sample_l     = il;
        sample_r     = ir;
        sample_valid = 1'b1;
        @(negedge clk_in);
        sample_valid = 1'b0;
        hi_wait      = HALF - 1 - LAT;
      end
    end
    repeat (hi_wait) @(negedge clk_in);
  endtask

  task automatic run_ch(input logic lr, input int n);
    for (int i = 0; i < n; i++) bclk_cycle(lr, 0, '0, '0);
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int waited = 0;
    @(negedge clk_in);
    sample_l     = l;
    sample_r     = r;
    sample_valid = 1'b1;
    while (sample_ready !== 1'b1 && waited < 3000 && !stop_prod) begin
      @(negedge clk_in);
      waited++;
    end
    if (sample_ready === 1'b1) @(negedge clk_in);
    else if (!stop_prod) check("handshake_timeout", 32'(sample_ready), 32'd1);
    sample_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got=running want=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  logic [DATA_W-1:0] pa_l, pa_r, pc_l, pc_r;

  initial begin
    rst_n        = 1'b0;
    bclk_in      = 1'b0;
    lrclk_in     = 1'b0;
    sample_l     = '0;
    sample_r     = '0;
    sample_valid = 1'b0;
    cmp_on       = 1'b1;

    // Reset held with the inputs toggling
    repeat (40) begin
      @(negedge clk_in);
      bclk_in      = 1'($urandom);
      lrclk_in     = 1'($urandom);
      sample_valid = 1'($urandom);
      sample_l     = 16'($urandom);
    end
    @(negedge clk_in);
    bclk_in      = 1'b0;
    lrclk_in     = 1'b0;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);
    check("post_reset_sdata", 32'(sdata_out), 32'd0);
    check("post_reset_ready", 32'(sample_ready), 32'd1);

    // Basic frame
    und_cnt = 0;
    send_pair(16'hA5F0, 16'h0F5A);
    check("ready_after_accept", 32'(sample_ready), 32'd0);
    run_ch(1'b0, 2);
    run_ch(1'b1, 16);
    run_ch(1'b0, 16);
    run_ch(1'b1, 16);
    check("basic_left_word", 32'(rx_last_l), 32'hA5F0);
    check("basic_no_underrun", 32'(und_cnt), 32'd0);

    // Three frames with no producer
    und_cnt = 0;
    run_ch(1'b0, 16);
    check("basic_right_word", 32'(rx_last_r), 32'h0F5A);
    run_ch(1'b1, 16);
    run_ch(1'b0, 16);
    run_ch(1'b1, 16);
    run_ch(1'b0, 16);
    run_ch(1'b1, 16);
    check("underrun_pulses", 32'(und_cnt), 32'd3);
    check("underrun_left_silent", 32'(rx_last_l), 32'h0000);

    // 24 BCLK per channel: zero padding after the word
    send_pair(16'hFFFF, 16'h3C3C);
    run_ch(1'b0, 24);
    run_ch(1'b1, 24);
    check("pad_left_word", 32'(rx_last_l), 32'hFFFF);
    check("pad_right_word", 32'(rx_last_r), 32'h3C3C);

    // Pair offered on the exact left-boundary edge with an empty buffer
    und_cnt   = 0;
    ready_low = 0;
    bclk_cycle(1'b0, 1, 16'h8001, 16'h7E7E);
    run_ch(1'b0, 15);
    run_ch(1'b1, 16);
    check("direct_left_word", 32'(rx_last_l), 32'h8001);
    check("direct_no_underrun", 32'(und_cnt), 32'd0);
    check("direct_ready_stayed_high", 32'(ready_low), 32'd0);

    // Reset pulse during bit 7 of a left word, then a clean frame
    pa_l = 16'($urandom);
    pa_r = 16'($urandom);
    send_pair(pa_l, pa_r);
    run_ch(1'b0, 7);
    check("direct_right_word", 32'(rx_last_r), 32'h7E7E);
    bclk_cycle(1'b0, 2, '0, '0);
    run_ch(1'b0, 8);
    pc_l = 16'($urandom) ^ 16'h5A5A;
    pc_r = 16'($urandom);
    send_pair(pc_l, pc_r);
    run_ch(1'b1, 16);
    run_ch(1'b0, 16);
    run_ch(1'b1, 16);
    run_ch(1'b0, 1);
    check("after_reset_left", 32'(rx_last_l), 32'(pc_l));
    check("after_reset_right", 32'(rx_last_r), 32'(pc_r));

    // Random channel lengths (truncated and padded) with a random producer
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          run_ch(1'b1, int'($urandom_range(22, 10)));
          run_ch(1'b0, int'($urandom_range(22, 10)));
        end
        stop_prod = 1'b1;
      end
      begin
        while (!stop_prod) begin
          repeat ($urandom_range(400, 0)) @(negedge clk_in);
          if (!stop_prod) send_pair(16'($urandom), 16'($urandom));
        end
      end
    join

    repeat (4) @(negedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
